// File: rtl/instr_issue_unit.sv
// Instruction issue unit: fetches from a small loadable imem, decodes, and feeds the
// 3-stage pipeline, inserting bubbles on RAW hazards (no forwarding) and draining on HALT.
//
// state | meaning
// IDLE  | after reset; loads and start accepted
// RUN   | fetch/decode/issue one word (or bubble) per cycle
// DRAIN | emit 3 bubbles so the pipeline retires its last instruction
// DONE  | program finished; loads and start accepted
module instr_issue_unit #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load_en,
  input  logic [AW-1:0] i_load_addr,
  input  logic [31:0]   i_load_data,
  input  logic          i_start,
  output logic [4:0]    o_rs1,
  output logic [4:0]    o_rs2,
  output logic [4:0]    o_rd,
  output logic [3:0]    o_func,
  output logic [31:0]   o_addr,
  output logic          o_issue_valid,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_pc,
  output logic [15:0]   o_bubble_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [3:0]    FUNC_HALT   = 4'hE;
  localparam logic [3:0]    FUNC_BUBBLE = 4'hF;
  localparam logic [AW-1:0] PC_LAST     = AW'(DEPTH - 1);

  logic [31:0]   r_imem [DEPTH];
  state_t        r_state, w_next_state;
  logic [AW-1:0] r_pc, w_pc_next;
  logic [4:0]    r_h1, r_h2;
  logic [1:0]    r_drain_cnt, w_drain_cnt_next;
  logic [15:0]   r_bubble_cnt;

  logic [4:0]    r_rs1, r_rs2, r_rd;
  logic [3:0]    r_func;
  logic [31:0]   r_addr;
  logic          r_issue_valid, r_busy, r_done;

  logic          w_accept_cmd;
  logic [31:0]   w_instr;
  logic [3:0]    w_func;
  logic [4:0]    w_rd, w_rs1, w_rs2;
  logic [12:0]   w_imm;
  logic          w_is_halt, w_hazard;
  logic          w_issue, w_hz_bubble, w_clear;

  assign w_accept_cmd = (r_state == S_IDLE) || (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (i_load_en && w_accept_cmd) r_imem[i_load_addr] <= i_load_data;
  end

  assign w_instr   = r_imem[r_pc];
  assign w_func    = w_instr[3:0];
  assign w_rd      = w_instr[8:4];
  assign w_rs1     = w_instr[13:9];
  assign w_rs2     = w_instr[18:14];
  assign w_imm     = w_instr[31:19];
  assign w_is_halt = (w_func == FUNC_HALT);

  // A nonzero source can never match a zero history slot, so bubbles never cause stalls.
  assign w_hazard = ((w_rs1 != 5'd0) && ((w_rs1 == r_h1) || (w_rs1 == r_h2))) ||
                    ((w_rs2 != 5'd0) && ((w_rs2 == r_h1) || (w_rs2 == r_h2)));

  always_comb begin
    w_next_state     = r_state;
    w_pc_next        = r_pc;
    w_drain_cnt_next = r_drain_cnt;
    w_issue          = 1'b0;
    w_hz_bubble      = 1'b0;
    w_clear          = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_next_state = S_RUN;
          w_pc_next    = '0;
          w_clear      = 1'b1;
        end
      end
      S_RUN: begin
        if (w_is_halt) begin
          w_next_state     = S_DRAIN;
          w_drain_cnt_next = 2'd0;
        end else if (w_hazard) begin
          w_hz_bubble = 1'b1;
        end else begin
          w_issue = 1'b1;
          if (r_pc == PC_LAST) begin
            w_next_state     = S_DRAIN;
            w_drain_cnt_next = 2'd0;
          end else begin
            w_pc_next = r_pc + AW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == 2'd2) w_next_state = S_DONE;
        else                     w_drain_cnt_next = r_drain_cnt + 2'd1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_h1          <= 5'd0;
      r_h2          <= 5'd0;
      r_drain_cnt   <= 2'd0;
      r_bubble_cnt  <= 16'd0;
      r_rs1         <= 5'd0;
      r_rs2         <= 5'd0;
      r_rd          <= 5'd0;
      r_func        <= FUNC_BUBBLE;
      r_addr        <= 32'd0;
      r_issue_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_pc        <= w_pc_next;
      r_drain_cnt <= w_drain_cnt_next;

      if (w_clear) begin
        r_h1         <= 5'd0;
        r_h2         <= 5'd0;
        r_bubble_cnt <= 16'd0;
      end else if (r_state == S_RUN) begin
        r_h2 <= r_h1;
        r_h1 <= w_issue ? w_rd : 5'd0;
        if (w_hz_bubble && (r_bubble_cnt != 16'hFFFF)) r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end

      if (w_issue) begin
        r_rs1         <= w_rs1;
        r_rs2         <= w_rs2;
        r_rd          <= w_rd;
        r_func        <= w_func;
        r_addr        <= {19'd0, w_imm};
        r_issue_valid <= 1'b1;
      end else begin
        r_rs1         <= 5'd0;
        r_rs2         <= 5'd0;
        r_rd          <= 5'd0;
        r_func        <= FUNC_BUBBLE;
        r_addr        <= 32'd0;
        r_issue_valid <= 1'b0;
      end

      r_busy <= (w_next_state == S_RUN) || (w_next_state == S_DRAIN);
      r_done <= (w_next_state == S_DONE);
    end
  end

  assign o_rs1         = r_rs1;
  assign o_rs2         = r_rs2;
  assign o_rd          = r_rd;
  assign o_func        = r_func;
  assign o_addr        = r_addr;
  assign o_issue_valid = r_issue_valid;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_pc          = r_pc;
  assign o_bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_instr_issue_unit.sv
// Bench for instr_issue_unit: programs are run against a timeline model in which an
// instruction may issue only once every source it reads was written >=3 cycles earlier.
module tb_instr_issue_unit;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam logic [51:0] BUBBLE = {1'b0, 15'd0, 4'hF, 32'd0};

  logic          clk = 1'b0;
  logic          reset;
  logic          i_load_en;
  logic [AW-1:0] i_load_addr;
  logic [31:0]   i_load_data;
  logic          i_start;
  logic [4:0]    o_rs1, o_rs2, o_rd;
  logic [3:0]    o_func;
  logic [31:0]   o_addr;
  logic          o_issue_valid, o_busy, o_done;
  logic [AW-1:0] o_pc;
  logic [15:0]   o_bubble_cnt;

  instr_issue_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .i_load_en(i_load_en), .i_load_addr(i_load_addr), .i_load_data(i_load_data),
    .i_start(i_start),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_func(o_func), .o_addr(o_addr),
    .o_issue_valid(o_issue_valid), .o_busy(o_busy), .o_done(o_done),
    .o_pc(o_pc), .o_bubble_cnt(o_bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  f;
    logic [31:0] a;
    logic [3:0]  pc;
    logic [15:0] cnt;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] tb_mem [DEPTH];
  exp_t        exp_q [$];
  logic        obs_v [$];
  logic [31:0] obs_a [$];
  int          exp_pc_final;
  int          exp_cnt_final;

  function automatic logic [31:0] enc(input int f, input int rd, input int rs1,
                                      input int rs2, input int imm);
    logic [3:0]  lf  = 4'(f);
    logic [4:0]  lrd = 5'(rd);
    logic [4:0]  ls1 = 5'(rs1);
    logic [4:0]  ls2 = 5'(rs2);
    logic [12:0] lim = 13'(imm);
    return {lim, ls2, ls1, lrd, lf};
  endfunction

  function automatic logic [31:0] halt_w();
    return enc(14, 0, 0, 0, 0);
  endfunction

  function automatic void build_model();
    int          last_wr [32];
    int          pc, bub;
    bit          fin;
    logic [31:0] w;
    exp_t        e;
    exp_q.delete();
    foreach (last_wr[r]) last_wr[r] = -10;
    pc = 0; bub = 0; fin = 0;
    for (int t = 0; t < 200; t++) begin
      w = tb_mem[pc];
      e.v = 1'b0; e.rs1 = 5'd0; e.rs2 = 5'd0; e.rd = 5'd0; e.f = 4'hF; e.a = 32'd0;
      if (w[3:0] == 4'hE) begin
        fin = 1;
      end else if ((w[13:9] != 0 && t - last_wr[w[13:9]] < 3) ||
                   (w[18:14] != 0 && t - last_wr[w[18:14]] < 3)) begin
        bub++;
      end else begin
        e.v = 1'b1; e.rs1 = w[13:9]; e.rs2 = w[18:14]; e.rd = w[8:4];
        e.f = w[3:0]; e.a = {19'd0, w[31:19]};
        if (w[8:4] != 0) last_wr[w[8:4]] = t;
        if (pc == DEPTH - 1) fin = 1;
        else pc++;
      end
      e.pc = 4'(pc); e.cnt = 16'(bub);
      exp_q.push_back(e);
      if (fin) break;
    end
    exp_pc_final  = pc;
    exp_cnt_final = bub;
  endfunction

  task automatic load_all();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      i_load_en = 1'b1; i_load_addr = 4'(i); i_load_data = tb_mem[i];
    end
    @(negedge clk);
    i_load_en = 1'b0;
  endtask

  task automatic do_start(input bit with_load, input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    i_start = 1'b1;
    if (with_load) begin
      i_load_en = 1'b1; i_load_addr = a; i_load_data = d;
      tb_mem[a] = d;
    end
    @(negedge clk);
    i_start = 1'b0; i_load_en = 1'b0;
  endtask

  // inj: 0 none, 1 load to imem while busy, 2 start pulse while busy
  task automatic run_check(input string name, input int inj,
                           input logic [3:0] ia, input logic [31:0] id);
    logic [51:0] got, want;
    logic [21:0] sgot, swant;
    build_model();
    obs_v.delete(); obs_a.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      i_load_en = 1'b0; i_start = 1'b0;
      got  = {o_issue_valid, o_rs1, o_rs2, o_rd, o_func, o_addr};
      want = {exp_q[i].v, exp_q[i].rs1, exp_q[i].rs2, exp_q[i].rd, exp_q[i].f, exp_q[i].a};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL %s issue[%0d] got=%h expected=%h", name, i, got, want);
      end
      sgot  = {o_busy, o_done, o_pc, o_bubble_cnt};
      swant = {2'b10, exp_q[i].pc, exp_q[i].cnt};
      checks++;
      if (sgot !== swant) begin
        failures++;
        $display("FAIL %s status[%0d] busy/done/pc/cnt got=%h expected=%h", name, i, sgot, swant);
      end
      obs_v.push_back(o_issue_valid);
      obs_a.push_back(o_addr);
      if (i == 1 && inj == 1) begin
        i_load_en = 1'b1; i_load_addr = ia; i_load_data = id;
      end
      if (i == 1 && inj == 2) i_start = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_load_en = 1'b0; i_start = 1'b0;
      got   = {o_issue_valid, o_rs1, o_rs2, o_rd, o_func, o_addr};
      sgot  = {o_busy, o_done, o_pc, o_bubble_cnt};
      swant = {(i == 2) ? 2'b01 : 2'b10, 4'(exp_pc_final), 16'(exp_cnt_final)};
      checks++;
      if (got !== BUBBLE || sgot !== swant) begin
        failures++;
        $display("FAIL %s drain[%0d] out=%h status=%h expected out=%h status=%h",
                 name, i, got, sgot, BUBBLE, swant);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_issue_valid, o_rs1, o_rs2, o_rd, o_func, o_addr} !== BUBBLE ||
        {o_busy, o_done, o_pc, o_bubble_cnt} !== 22'd0) begin
      failures++;
      $display("FAIL reset_state out=%h busy=%b done=%b pc=%0d cnt=%0d expected bubble/0",
               {o_issue_valid, o_rs1, o_rs2, o_rd, o_func, o_addr}, o_busy, o_done, o_pc, o_bubble_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_raw_hazard();
    foreach (tb_mem[i]) tb_mem[i] = halt_w();
    tb_mem[0] = enc(0, 1, 2, 3, 0);
    tb_mem[1] = enc(0, 4, 1, 5, 0);
    load_all();
    do_start(0, 0, 0);
    run_check("raw_hazard", 0, 0, 0);
    checks++;
    if ({obs_v[0], obs_v[1], obs_v[2], obs_v[3]} !== 4'b1001) begin
      failures++;
      $display("FAIL raw_valid_pattern got=%b expected=1001", {obs_v[0], obs_v[1], obs_v[2], obs_v[3]});
    end
    checks++;
    if (o_bubble_cnt !== 16'd2 || o_pc !== 4'd2) begin
      failures++;
      $display("FAIL raw_final cnt=%0d pc=%0d expected cnt=2 pc=2", o_bubble_cnt, o_pc);
    end
  endtask

  task automatic test_single_bubble();
    foreach (tb_mem[i]) tb_mem[i] = halt_w();
    tb_mem[0] = enc(0, 1, 2, 3, 0);
    tb_mem[1] = enc(1, 6, 7, 8, 0);
    tb_mem[2] = enc(2, 9, 1, 0, 0);
    load_all();
    do_start(0, 0, 0);
    run_check("single_bubble", 0, 0, 0);
    checks++;
    if ({obs_v[0], obs_v[1], obs_v[2], obs_v[3]} !== 4'b1101 || o_bubble_cnt !== 16'd1) begin
      failures++;
      $display("FAIL single_bubble pattern=%b cnt=%0d expected 1101 cnt=1",
               {obs_v[0], obs_v[1], obs_v[2], obs_v[3]}, o_bubble_cnt);
    end
  endtask

  task automatic test_independent();
    foreach (tb_mem[i]) tb_mem[i] = halt_w();
    tb_mem[0] = enc(3, 1, 10, 11, 'h1ABC);
    tb_mem[1] = enc(4, 2, 12, 13, 5);
    tb_mem[2] = enc(5, 3, 14, 15, 'h1FFF);
    tb_mem[3] = enc(15, 4, 16, 17, 0);
    load_all();
    do_start(0, 0, 0);
    run_check("independent", 0, 0, 0);
    checks++;
    if ({obs_v[0], obs_v[1], obs_v[2], obs_v[3]} !== 4'b1111 || o_bubble_cnt !== 16'd0 ||
        obs_a[0] !== 32'h0000_1ABC) begin
      failures++;
      $display("FAIL independent pattern=%b cnt=%0d addr0=%h expected 1111 cnt=0 addr0=00001abc",
               {obs_v[0], obs_v[1], obs_v[2], obs_v[3]}, o_bubble_cnt, obs_a[0]);
    end
  endtask

  task automatic test_full_depth_zero_reg();
    tb_mem[0] = enc(0, 0, 5, 6, 1);
    tb_mem[1] = enc(1, 7, 0, 0, 2);
    for (int i = 2; i < DEPTH; i++) tb_mem[i] = enc(i % 14, i + 10, 0, 0, i);
    load_all();
    do_start(0, 0, 0);
    run_check("full_depth", 0, 0, 0);
    checks++;
    if (exp_q.size() != DEPTH || o_pc !== 4'(DEPTH - 1) || o_bubble_cnt !== 16'd0 || o_done !== 1'b1) begin
      failures++;
      $display("FAIL full_depth_end pc=%0d cnt=%0d done=%b expected pc=%0d cnt=0 done=1",
               o_pc, o_bubble_cnt, o_done, DEPTH - 1);
    end
  endtask

  task automatic test_load_during_run();
    foreach (tb_mem[i]) tb_mem[i] = halt_w();
    tb_mem[0] = enc(2, 1, 20, 21, 'h0AA);
    tb_mem[1] = enc(3, 2, 22, 23, 0);
    tb_mem[2] = enc(4, 3, 24, 25, 0);
    load_all();
    do_start(0, 0, 0);
    run_check("load_in_run", 1, 4'd0, enc(9, 30, 31, 31, 'h155));
    do_start(0, 0, 0);
    run_check("rerun_after_load", 0, 0, 0);
    checks++;
    if (obs_a[0] !== 32'h0000_00AA) begin
      failures++;
      $display("FAIL imem_unchanged addr0=%h expected=000000aa", obs_a[0]);
    end
  endtask

  task automatic test_load_with_start();
    do_start(1, 4'd0, enc(6, 9, 0, 0, 'h777));
    run_check("load_with_start", 0, 0, 0);
    checks++;
    if (obs_a[0] !== 32'h0000_0777) begin
      failures++;
      $display("FAIL load_with_start addr0=%h expected=00000777", obs_a[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    foreach (tb_mem[i]) tb_mem[i] = halt_w();
    for (int i = 0; i < 8; i++) tb_mem[i] = enc(i, i + 1, 20, 21, i);
    load_all();
    do_start(0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (o_pc !== 4'd3 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_run_pc pc=%0d busy=%b expected pc=3 busy=1", o_pc, o_busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_issue_valid, o_rs1, o_rs2, o_rd, o_func, o_addr} !== BUBBLE ||
          {o_busy, o_done, o_pc, o_bubble_cnt} !== 22'd0) begin
        failures++;
        $display("FAIL reset_mid_run[%0d] out=%h busy=%b done=%b pc=%0d expected bubble idle pc=0",
                 k, {o_issue_valid, o_rs1, o_rs2, o_rd, o_func, o_addr}, o_busy, o_done, o_pc);
      end
      @(negedge clk);
    end
    do_start(0, 0, 0);
    run_check("rerun_after_reset", 0, 0, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      foreach (tb_mem[i]) begin
        if ($urandom_range(0, 9) == 0) tb_mem[i] = halt_w();
        else tb_mem[i] = enc($urandom_range(0, 13), $urandom_range(0, 3), $urandom_range(0, 3),
                             $urandom_range(0, 3), $urandom_range(0, 8191));
      end
      load_all();
      do_start(0, 0, 0);
      run_check("random", it % 3, 4'($urandom_range(0, 15)), $urandom);
    end
  endtask

  initial begin
    reset = 1'b1; i_load_en = 1'b0; i_load_addr = '0; i_load_data = '0; i_start = 1'b0;
    test_reset();
    test_raw_hazard();
    test_single_bubble();
    test_independent();
    test_full_depth_zero_reg();
    test_load_during_run();
    test_load_with_start();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
